// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared defaults and FSM encoding for the two-requester write-port arbiter
package wb_arb_pkg;

    localparam int WB_ARB_WIDTH = 32;
    localparam int WB_ARB_AW    = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_A = 2'd1,
        HOLD_B = 2'd2
    } state_e;

    function automatic state_e hold_state(input logic src_b);
        return src_b ? HOLD_B : HOLD_A;
    endfunction

endpackage

// File: rtl/wb_mux2.sv
// rtl/wb_mux2.sv - 2:1 payload select, sel=1 picks in1 (requester B)
module wb_mux2 #(
    parameter int W = 37
) (
    input  logic         sel,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    output logic [W-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/wb_mux_arbiter.sv
// rtl/wb_mux_arbiter.sv - two-requester arbiter feeding one registered output beat
// Build option: WB_ARB_RR_EN selects round-robin arbitration instead of fixed A priority.
module wb_mux_arbiter
    import wb_arb_pkg::*;
#(
    parameter int WIDTH = WB_ARB_WIDTH,
    parameter int AW    = WB_ARB_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic [AW-1:0]    a_addr,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic [AW-1:0]    b_addr,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [AW-1:0]    out_addr,
    output logic             out_src,
    input  logic             out_ready
);

    localparam int PW = WIDTH + AW;

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [AW-1:0]    out_addr_q, out_addr_d;
    logic             out_src_q, out_src_d;
    logic             slot_free;
    logic             grant_b;
    logic             accept;
    logic [PW-1:0]    sel_payload;

`ifdef WB_ARB_RR_EN
    // rr_ptr_q=1 means B wins the next conflict
    logic rr_ptr_q, rr_ptr_d;
`endif

    always_comb begin
        slot_free = !out_valid_q || out_ready;
`ifdef WB_ARB_RR_EN
        grant_b = b_valid && (!a_valid || rr_ptr_q);
`else
        grant_b = b_valid && !a_valid;
`endif
        // Readies are held low while reset is asserted, not just after the first edge
        a_ready = rst_n && slot_free && a_valid && !grant_b;
        b_ready = rst_n && slot_free && grant_b;
        accept  = a_ready || b_ready;
    end

    wb_mux2 #(
        .W (PW)
    ) u_mux2 (
        .sel (grant_b),
        .in0 ({a_data, a_addr}),
        .in1 ({b_data, b_addr}),
        .out (sel_payload)
    );

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_addr_d = out_addr_q;
        out_src_d  = out_src_q;
`ifdef WB_ARB_RR_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) state_d = hold_state(grant_b);
            end
            HOLD_A, HOLD_B: begin
                if (out_ready) state_d = accept ? hold_state(grant_b) : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            {out_data_d, out_addr_d} = sel_payload;
            out_src_d                = grant_b;
`ifdef WB_ARB_RR_EN
            rr_ptr_d                 = !grant_b;
`endif
        end
        out_valid_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_src_q   <= 1'b0;
`ifdef WB_ARB_RR_EN
            rr_ptr_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_src_q   <= out_src_d;
`ifdef WB_ARB_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_wb_mux_arbiter.sv
// tb/tb_wb_mux_arbiter.sv - directed self-checking bench for wb_mux_arbiter (either arbitration build)
module tb_wb_mux_arbiter;
    import wb_arb_pkg::*;

`ifdef WB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [31:0] a_data, b_data, out_data;
    logic [4:0]  a_addr, b_addr, out_addr;
    logic        out_valid, out_src, out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_mux_arbiter #(.WIDTH(32), .AW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_addr    (a_addr),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_addr    (b_addr),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_b;

        rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b0;
        a_data = '0; a_addr = '0; b_data = '0; b_addr = '0; out_ready = 1'b0;
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_addr",  64'(out_addr),  64'd0);
        chk("rst_out_src",   64'(out_src),   64'd0);
        chk("rst_a_ready",   64'(a_ready),   64'd0);
        chk("rst_b_ready",   64'(b_ready),   64'd0);
        a_valid = 1'b0;
        #20 rst_n = 1'b1;
        tick();

        // single A beat, latency 1
        a_valid = 1'b1; a_data = 32'hFFFFAAAA; a_addr = 5'd5; out_ready = 1'b1;
        #1;
        chk("single_a_ready", 64'(a_ready), 64'd1);
        chk("single_b_ready", 64'(b_ready), 64'd0);
        tick();
        a_valid = 1'b0;
        chk("single_out_valid", 64'(out_valid), 64'd1);
        chk("single_out_data",  64'(out_data),  64'hFFFFAAAA);
        chk("single_out_addr",  64'(out_addr),  64'd5);
        chk("single_out_src",   64'(out_src),   64'd0);

        // drain with no requesters
        tick();
        chk("drain_out_valid", 64'(out_valid), 64'd0);
        chk("drain_state",     64'(dut.state_q), 64'(IDLE));

        // backpressure: hold A beat, B waits
        a_valid = 1'b1; a_data = 32'hFFFFFFFF; a_addr = 5'd31;
        tick();
        a_valid = 1'b0; out_ready = 1'b0;
        b_valid = 1'b1; b_data = 32'h12345678; b_addr = 5'd9;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_a_ready",   64'(a_ready),   64'd0);
            chk("bp_b_ready",   64'(b_ready),   64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_data",  64'(out_data),  64'hFFFFFFFF);
            chk("bp_out_addr",  64'(out_addr),  64'd31);
            chk("bp_out_src",   64'(out_src),   64'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_b_ready", 64'(b_ready), 64'd1);
        tick();
        b_valid = 1'b0; out_ready = 1'b0;
        chk("bp_b_out_valid", 64'(out_valid), 64'd1);
        chk("bp_b_out_data",  64'(out_data),  64'h12345678);
        chk("bp_b_out_addr",  64'(out_addr),  64'd9);
        chk("bp_b_out_src",   64'(out_src),   64'd1);
        chk("bp_b_state",     64'(dut.state_q), 64'(HOLD_B));

        // asynchronous reset while a beat is held
        #2;
        rst_n = 1'b0; a_valid = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_data",  64'(out_data),  64'd0);
        chk("arst_a_ready",   64'(a_ready),   64'd0);
        chk("arst_b_ready",   64'(b_ready),   64'd0);
        chk("arst_state",     64'(dut.state_q), 64'(IDLE));
        a_valid = 1'b0;
        #1 rst_n = 1'b1;
        tick();

        // conflict: both valid, drain every cycle
        a_valid = 1'b1; a_data = 32'h6666AFAF; a_addr = 5'd3;
        b_valid = 1'b1; b_data = 32'hAFAF1010; b_addr = 5'd7;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_b = RR ? 1'(i % 2) : 1'b0;
            #1;
            chk("cf_a_ready", 64'(a_ready), 64'(!exp_b));
            chk("cf_b_ready", 64'(b_ready), 64'(exp_b));
            tick();
            chk("cf_out_valid", 64'(out_valid), 64'd1);
            chk("cf_out_src",   64'(out_src),   64'(exp_b));
            chk("cf_out_data",  64'(out_data),  exp_b ? 64'hAFAF1010 : 64'h6666AFAF);
            chk("cf_out_addr",  64'(out_addr),  exp_b ? 64'd7 : 64'd3);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        chk("cf_drain_valid", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
